// File: rtl/mult_sequencer.sv
// Arithmetic-side multiply sequencer: steps multiplier digits as odd/even minor-cycle
// pairs (conditional add, then shift), issues da/ds/dy and waits for the ep1 end pulse.
module mult_sequencer #(
  parameter int DIGITS     = 36,
  parameter int LONG_BITS  = 35,
  parameter int SHORT_BITS = 17,
  parameter int EP_TIMEOUT = 72
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic long_mode,
  input  logic d0,
  input  logic ev,
  input  logic mplier_bit,
  input  logic ep1,
  output logic busy,
  output logic da,
  output logic add_en,
  output logic ds,
  output logic g5,
  output logic dy,
  output logic err
);

  localparam int CW = $clog2(LONG_BITS + 1);
  localparam int WW = $clog2(DIGITS);
  localparam int TW = $clog2(EP_TIMEOUT + 1);
  localparam logic [WW-1:0] WIN_LOAD = WW'(DIGITS - 1);
  localparam logic [TW-1:0] TIMEOUT  = TW'(EP_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    STEP_ADD,
    STEP_SHIFT,
    FINAL,
    WAIT_EP
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [TW-1:0] tcount, tcount_next, tcount_inc;
  logic [WW-1:0] win, win_next;
  logic          add_bit, add_bit_next;
  logic          err_next;
  logic          start_q;
  logic          ev_d0, odd_d0, accept;

  assign ev_d0      = d0 & ev;
  assign odd_d0     = d0 & ~ev;
  assign tcount_inc = tcount + TW'(1);
  // start_q powers up high so a start level held through reset is not taken as a new order
  assign accept     = start & ~start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      tcount  <= '0;
      win     <= '0;
      add_bit <= 1'b0;
      err     <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state   <= state_next;
      count   <= count_next;
      tcount  <= tcount_next;
      win     <= win_next;
      add_bit <= add_bit_next;
      err     <= err_next;
      start_q <= start;
    end
  end

  // win counts the remaining clocks of the add or shift window opened at the last d0
  always_comb begin
    state_next   = state;
    count_next   = count;
    tcount_next  = tcount;
    win_next     = (win != '0) ? win - WW'(1) : '0;
    add_bit_next = add_bit;
    err_next     = err;
    busy         = (state != IDLE);
    da           = 1'b0;
    add_en       = 1'b0;
    ds           = 1'b0;
    g5           = 1'b0;
    dy           = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          count_next = long_mode ? CW'(LONG_BITS) : CW'(SHORT_BITS);
          state_next = ARM;
        end
      end
      ARM: begin
        if (ev_d0) begin
          da         = 1'b1;
          state_next = STEP_ADD;
        end
      end
      STEP_ADD: begin
        g5 = (win != '0);
        if (odd_d0) begin
          add_en       = mplier_bit;
          add_bit_next = mplier_bit;
          win_next     = WIN_LOAD;
          state_next   = STEP_SHIFT;
        end
      end
      STEP_SHIFT: begin
        add_en = add_bit & (win != '0);
        if (ev_d0) begin
          ds         = 1'b1;
          g5         = 1'b1;
          win_next   = WIN_LOAD;
          count_next = count - CW'(1);
          state_next = (count == CW'(1)) ? FINAL : STEP_ADD;
        end
      end
      FINAL: begin
        g5 = (win != '0);
        if (ev_d0) begin
          dy = 1'b1;
          if (ep1) begin
            state_next = IDLE;
          end else begin
            tcount_next = TW'(1);
            state_next  = WAIT_EP;
          end
        end
      end
      WAIT_EP: begin
        dy = 1'b1;
        if (ep1) begin
          state_next = IDLE;
        end else if (tcount_inc == TIMEOUT) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tcount_next = tcount_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Arithmetic-unit side of the multiply/shift control handshake; the producer of the da/dy/ds pulses that the multiply control unit consumes, and the consumer of its ep1 end pulse.
- On a multiply order it steps serially through multiplier digits, one digit per pair of minor cycles:
  - odd minor cycle: conditional add of the multiplicand;
  - even minor cycle: accumulator right shift.
- It then raises dy at an even-d0 slot and waits for ep1 to close the operation.
- Sits between order decode and the accumulator/multiplier registers.

Parameters:
DIGITS, 36, clocks per minor cycle (d0..d35)
LONG_BITS, 35, multiplier digits stepped in long mode
SHORT_BITS, 17, multiplier digits stepped in short mode
EP_TIMEOUT, 72, clocks to wait for ep1 after dy before flagging error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-clock multiply-order request from order decode
long_mode  in  1  1 = long (LONG_BITS) multiply, sampled with start
d0  in  1  one-clock strobe at digit 0 of every minor cycle
ev  in  1  1 = current minor cycle is even; stable across the minor cycle
mplier_bit  in  1  current multiplier digit (LSB first), valid at odd d0
ep1  in  1  end pulse from multiply control
busy  out  1  operation in progress
da  out  1  one-clock sign-test pulse, start of sequence
add_en  out  1  gates multiplicand into accumulator for one odd minor cycle
ds  out  1  one-clock right-shift sign-propagate pulse, even d0
g5  out  1  accumulator shift gate, held for one even minor cycle
dy  out  1  multiplier-exhausted pulse, held until ep1 or timeout
err  out  1  sticky: ep1 not received within EP_TIMEOUT

Behaviour:
- Reset: all outputs 0, state IDLE, digit count 0, timeout counter 0, err cleared. Applies mid-operation: the sequence aborts and dy is not issued.
- ev_d0 = d0 & ev; odd_d0 = d0 & ~ev.
- Count width: clog2(LONG_BITS+1).
- States:
  - IDLE: on start, latch count = long_mode ? LONG_BITS : SHORT_BITS and go to ARM; busy rises the next clock. start is ignored while busy=1.
  - ARM: wait for ev_d0. An ev_d0 on the same clock as the accepted start is not used; the next ev_d0 is taken. On it, da=1 for that clock and go to STEP_ADD.
  - STEP_ADD:
    - at odd_d0, sample mplier_bit;
    - add_en = sampled bit for the DIGITS clocks starting at that d0;
    - then go to STEP_SHIFT.
  - STEP_SHIFT:
    - at ev_d0: ds=1 for one clock; g5=1 for that whole even minor cycle; count decrements;
    - if the new count is 0, go to FINAL, else to STEP_ADD.
  - FINAL: at the next ev_d0, assert dy and hold it; start the timeout counter; go to WAIT_EP.
  - WAIT_EP:
    - ep1=1 (may arrive on the same clock dy first rises): drop dy and busy next clock; go to IDLE.
    - Timeout counter reaches EP_TIMEOUT: set err, drop dy and busy, go to IDLE.
- ep1 outside WAIT_EP/FINAL is ignored.
- Timing, with SIGN (da) at clock T:
  - step k odd d0 = T+36+72(k-1);
  - step k even d0 = T+72k;
  - dy rises at T+72(N+1), where N = SHORT_BITS or LONG_BITS.
- add_en and g5 are never high in the same clock. da, ds and dy are never high in the same clock.
- err stays set until reset; it does not block new starts.

Test Plan:
- Reset with start=1 held → all outputs 0; after reset drops, start is accepted only on a fresh 1-clock pulse.
- Short multiply, mplier digits 1,0,1,0... → da at T; add_en high only in steps 1,3,5,...; 17 ds pulses at T+72k; dy at T+1296; ep1 same clock → busy low at T+1297.
- Long multiply, all digits 1 → 35 add_en windows of 36 clocks; 35 ds; dy at T+2592; err=0.
- start coincident with ev_d0 → da at the following ev_d0 (72 clocks later); start pulses during busy have no effect.
- dy issued, ep1 never arrives → err=1 and dy=0 exactly 72 clocks after dy rose; busy=0; next start proceeds normally with err still 1.
- reset asserted mid step 5 of a short multiply → next clock all outputs 0, state IDLE; no dy ever issued.
